// File: rtl/el2_clkgate_ctrl.sv
// Per-domain clock-gate enable controller: OFF/WAKE/ON/HOLD sequencing per domain.
// Optional per-domain gated-cycle statistics are enabled by defining RV_CG_STATS_EN.
module el2_clkgate_ctrl #(
    parameter int NDOM     = 4,
    parameter int IDLE_W   = 4,
    parameter int WAKE_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 scan_mode,
    input  logic                 cg_disable,
    input  logic [IDLE_W-1:0]    idle_cfg,
    input  logic [NDOM-1:0]      dom_busy,
    input  logic [NDOM-1:0]      dom_wake_req,
    output logic [NDOM-1:0]      dom_wake_ack,
    output logic [NDOM-1:0]      dom_cg_en,
    output logic [NDOM*16-1:0]   dom_off_cnt,
    input  logic                 stats_clr
);

    localparam int WCNT_W = (WAKE_LAT > 2) ? $clog2(WAKE_LAT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WAKE_LAT - 1);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_WAKE = 2'd1;
    localparam logic [1:0] ST_ON   = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

`ifdef RV_CG_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`else
    logic w_unused_stats_clr;
    assign w_unused_stats_clr = stats_clr;
`endif

    for (genvar g = 0; g < NDOM; g++) begin : g_dom
        logic [1:0]        r_state;
        logic [1:0]        w_state_nxt;
        logic [WCNT_W-1:0] r_wcnt;
        logic [WCNT_W-1:0] w_wcnt_nxt;
        logic [IDLE_W-1:0] r_hcnt;
        logic [IDLE_W-1:0] w_hcnt_nxt;
        logic              r_en;
        logic              r_ack;
        logic              w_act;

        assign w_act = dom_busy[g] | dom_wake_req[g] | cg_disable;

        // WAKE always runs to completion so the gate has settled before ack.
        always_comb begin
            w_state_nxt = r_state;
            w_wcnt_nxt  = r_wcnt;
            w_hcnt_nxt  = r_hcnt;
            case (r_state)
                ST_OFF: begin
                    if (w_act) begin
                        w_state_nxt = ST_WAKE;
                        w_wcnt_nxt  = WCNT_INIT;
                    end
                end
                ST_WAKE: begin
                    if (r_wcnt == '0) w_state_nxt = ST_ON;
                    else              w_wcnt_nxt  = r_wcnt - WCNT_W'(1);
                end
                ST_ON: begin
                    if (!w_act) begin
                        if (idle_cfg == '0) begin
                            w_state_nxt = ST_OFF;
                        end else begin
                            w_state_nxt = ST_HOLD;
                            w_hcnt_nxt  = idle_cfg;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_act)                        w_state_nxt = ST_ON;
                    else if (r_hcnt == IDLE_W'(1))    w_state_nxt = ST_OFF;
                    else                              w_hcnt_nxt  = r_hcnt - IDLE_W'(1);
                end
                default: w_state_nxt = ST_OFF;
            endcase
        end

        // EN and ack come straight from flops so the gate cell never sees a decode glitch.
        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                r_state <= ST_OFF;
                r_wcnt  <= '0;
                r_hcnt  <= '0;
                r_en    <= 1'b0;
                r_ack   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_wcnt  <= w_wcnt_nxt;
                r_hcnt  <= w_hcnt_nxt;
                r_en    <= (w_state_nxt != ST_OFF);
                r_ack   <= (w_state_nxt == ST_ON) || (w_state_nxt == ST_HOLD);
            end
        end

        assign dom_cg_en[g]    = r_en | scan_mode;
        assign dom_wake_ack[g] = r_ack;

`ifdef RV_CG_STATS_EN
        logic [15:0] r_off_cnt;

        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l)                  r_off_cnt <= 16'h0;
            else if (stats_clr)          r_off_cnt <= 16'h0;
            else if (r_state == ST_OFF)  r_off_cnt <= sat_inc16(r_off_cnt);
        end

        assign dom_off_cnt[g*16 +: 16] = r_off_cnt;
`else
        assign dom_off_cnt[g*16 +: 16] = 16'h0;
`endif
    end

endmodule

// File: tb/tb_el2_clkgate_ctrl.sv
// Testbench for el2_clkgate_ctrl: directed scenarios plus randomized traffic checked
// against a timestamp-based reference model of each domain's gate behaviour.
module tb_el2_clkgate_ctrl;

    localparam int NDOM     = 4;
    localparam int IDLE_W   = 4;
    localparam int WAKE_LAT = 2;
`ifdef RV_CG_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_l;
    logic                scan_mode;
    logic                cg_disable;
    logic [IDLE_W-1:0]   idle_cfg;
    logic [NDOM-1:0]     dom_busy;
    logic [NDOM-1:0]     dom_wake_req;
    logic [NDOM-1:0]     dom_wake_ack;
    logic [NDOM-1:0]     dom_cg_en;
    logic [NDOM*16-1:0]  dom_off_cnt;
    logic                stats_clr;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: per domain, whether EN is on, the edge at which ack appears,
    // the edge at which the gate will close (-1 = none scheduled), and the OFF count.
    bit     m_en[NDOM];
    longint m_ack_edge[NDOM];
    longint m_dl[NDOM];
    int     m_off[NDOM];
    longint k;

    always #5 clk = ~clk;

    el2_clkgate_ctrl #(.NDOM(NDOM), .IDLE_W(IDLE_W), .WAKE_LAT(WAKE_LAT)) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .scan_mode    (scan_mode),
        .cg_disable   (cg_disable),
        .idle_cfg     (idle_cfg),
        .dom_busy     (dom_busy),
        .dom_wake_req (dom_wake_req),
        .dom_wake_ack (dom_wake_ack),
        .dom_cg_en    (dom_cg_en),
        .dom_off_cnt  (dom_off_cnt),
        .stats_clr    (stats_clr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDOM; i++) begin
            m_en[i]       = 1'b0;
            m_ack_edge[i] = 0;
            m_dl[i]       = -1;
            m_off[i]      = 0;
        end
        k = 0;
    endtask

    task automatic model_step();
        bit act;
        for (int i = 0; i < NDOM; i++) begin
            act = dom_busy[i] | dom_wake_req[i] | cg_disable;
            if (stats_clr)                       m_off[i] = 0;
            else if (!m_en[i] && m_off[i] < 65535) m_off[i] = m_off[i] + 1;
            if (!m_en[i]) begin
                if (act) begin
                    m_en[i]       = 1'b1;
                    m_ack_edge[i] = k + WAKE_LAT;
                    m_dl[i]       = -1;
                end
            end else if (k > m_ack_edge[i]) begin
                if (act)                  m_dl[i] = -1;
                else if (m_dl[i] < 0) begin
                    if (idle_cfg == 0)    m_en[i] = 1'b0;
                    else                  m_dl[i] = k + longint'(idle_cfg);
                end else if (k == m_dl[i]) m_en[i] = 1'b0;
            end
        end
    endtask

    task automatic compare_model();
        logic [NDOM-1:0]    e_en;
        logic [NDOM-1:0]    e_ack;
        logic [NDOM*16-1:0] e_off;
        e_off = '0;
        for (int i = 0; i < NDOM; i++) begin
            e_en[i]  = m_en[i] | scan_mode;
            e_ack[i] = m_en[i] && (k >= m_ack_edge[i]);
            if (STATS) e_off[i*16 +: 16] = 16'(m_off[i]);
        end
        check("model_cg_en", 64'(dom_cg_en), 64'(e_en));
        check("model_wake_ack", 64'(dom_wake_ack), 64'(e_ack));
        check("model_off_cnt", dom_off_cnt, e_off);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_l) begin
            k++;
            model_step();
        end else begin
            model_reset();
        end
        #1;
        compare_model();
    endtask

    task automatic async_reset();
        rst_l = 1'b0;
        #1;
        model_reset();
        compare_model();
    endtask

    initial begin
        rst_l        = 1'b0;
        scan_mode    = 1'b0;
        cg_disable   = 1'b0;
        idle_cfg     = '0;
        dom_busy     = '0;
        dom_wake_req = '0;
        stats_clr    = 1'b0;
        model_reset();
        repeat (3) tick();
        check("rst_cg_en", 64'(dom_cg_en), 64'h0);
        check("rst_ack", 64'(dom_wake_ack), 64'h0);

        // Idle after reset: everything stays gated and OFF cycles accumulate
        rst_l = 1'b1;
        repeat (20) tick();
        check("idle_cg_en", 64'(dom_cg_en), 64'h0);
        check("idle_ack", 64'(dom_wake_ack), 64'h0);
        check("idle_off_cnt0", 64'(dom_off_cnt[15:0]), STATS ? 64'd20 : 64'd0);

        // Wake latency on domain 1
        dom_busy = 4'b0010;
        tick();
        check("wake_en_t1", 64'(dom_cg_en), 64'b0010);
        check("wake_ack_t1", 64'(dom_wake_ack), 64'b0000);
        tick();
        check("wake_ack_t2", 64'(dom_wake_ack), 64'b0000);
        tick();
        check("wake_ack_t3", 64'(dom_wake_ack), 64'b0010);

        // Idle hysteresis of 3 on domain 0
        idle_cfg = 4'd3;
        dom_busy = 4'b0001;
        repeat (3) tick();
        check("hold_on_ack", 64'(dom_wake_ack[0]), 64'd1);
        dom_busy = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("hold_en_held", 64'(dom_cg_en[0]), 64'd1);
        end
        tick();
        check("hold_en_off", 64'(dom_cg_en[0]), 64'd0);

        // Busy returns during the 2nd HOLD cycle: EN never drops
        dom_busy = 4'b0001;
        repeat (3) tick();
        dom_busy = 4'b0000;
        tick();
        tick();
        dom_busy = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("rehold_en", 64'(dom_cg_en[0]), 64'd1);
        end
        check("rehold_ack", 64'(dom_wake_ack[0]), 64'd1);

        // Zero hysteresis gates on the next edge
        idle_cfg = 4'd0;
        dom_busy = 4'b0000;
        tick();
        check("idle0_en", 64'(dom_cg_en[0]), 64'd0);
        repeat (4) tick();

        // cg_disable forces every domain on
        cg_disable = 1'b1;
        repeat (WAKE_LAT + 1) tick();
        check("cgdis_en", 64'(dom_cg_en), 64'hF);
        check("cgdis_ack", 64'(dom_wake_ack), 64'hF);
        repeat (5) tick();
        check("cgdis_stay", 64'(dom_wake_ack), 64'hF);
        cg_disable = 1'b0;
        tick();
        check("cgdis_release", 64'(dom_cg_en), 64'h0);

        // Async reset during WAKE, scan_mode during reset
        dom_busy = 4'b0100;
        tick();
        check("rstwake_pre", 64'(dom_cg_en), 64'b0100);
        async_reset();
        check("rstwake_en", 64'(dom_cg_en), 64'h0);
        scan_mode = 1'b1;
        #1;
        check("rst_scan_en", 64'(dom_cg_en), 64'hF);
        tick();
        tick();
        scan_mode = 1'b0;
        rst_l = 1'b1;

        // Async reset during HOLD
        idle_cfg = 4'd5;
        repeat (3) tick();
        check("rsthold_ack_pre", 64'(dom_wake_ack), 64'b0100);
        dom_busy = 4'b0000;
        tick();
        tick();
        async_reset();
        check("rsthold_en", 64'(dom_cg_en), 64'h0);
        check("rsthold_ack", 64'(dom_wake_ack), 64'h0);
        rst_l = 1'b1;
        scan_mode = 1'b1;
        #1;
        check("off_scan_en", 64'(dom_cg_en), 64'hF);
        tick();
        check("off_scan_ack", 64'(dom_wake_ack), 64'h0);
        scan_mode = 1'b0;
        tick();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            dom_busy     = NDOM'($urandom & $urandom);
            dom_wake_req = NDOM'($urandom & $urandom & $urandom);
            cg_disable   = ($urandom_range(0, 15) == 0);
            idle_cfg     = IDLE_W'($urandom);
            scan_mode    = ($urandom_range(0, 7) == 0);
            stats_clr    = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 99) == 0) begin
                async_reset();
                tick();
                rst_l = 1'b1;
            end
            tick();
        end
        dom_busy     = '0;
        dom_wake_req = '0;
        cg_disable   = 1'b0;
        scan_mode    = 1'b0;
        idle_cfg     = '0;

        // Saturation and clear-over-increment
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
`ifdef RV_CG_STATS_EN
        repeat (65540) tick();
        check("sat_cnt", 64'(dom_off_cnt[15:0]), 64'hFFFF);
`else
        repeat (30) tick();
`endif
        stats_clr = 1'b1;
        tick();
        check("clr_cnt", 64'(dom_off_cnt[15:0]), 64'h0);
        stats_clr = 1'b0;
        tick();
        check("post_clr_cnt", 64'(dom_off_cnt[15:0]), STATS ? 64'd1 : 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
